psum_drain: RTL and testbench

Accumulates partial-sum vectors emitted by the PE across multiple input passes and post-processes the finished tile into output activations. The block sits directly downstream of the PE's `Psum_out` rdyack port. It holds one output tile in a local register buffer, adds successive passes with saturation, then drains the tile with shift, ReLU and clamp to the next layer's activation width.

---
 rtl/psum_drain.sv | 198 +++++++++++++++++++
 tb/tb_psum_drain.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_drain.sv
// psum_drain: accumulates multi-pass partial-sum vectors for one output tile
// in a local register buffer, then drains the tile as post-processed
// activations (arithmetic shift, optional ReLU, clamp to DWD bits).
//
// Handshake (both ports): the sender drives rdy, the receiver drives ack, and
// a beat transfers on every cycle where rdy && ack. The sender holds its data
// stable while rdy is high and ack is low. Psum_ack is high for the whole of
// ACC, and Out_rdy is high for the whole of DRAIN. Neither ack depends on the
// matching rdy in the same cycle.
module psum_drain #(
  parameter int PEROW   = 16,
  parameter int PSUMDWD = 24,
  parameter int ACCWD   = 28,
  parameter int DWD     = 8,
  parameter int DEPTH   = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic [$clog2(DEPTH)-1:0]   i_tile_len,
  input  logic [7:0]                 i_num_pass,
  input  logic [4:0]                 i_shift,
  input  logic                       i_relu,
  input  logic                       Psum_rdy,
  output logic                       Psum_ack,
  input  logic [PEROW*PSUMDWD-1:0]   i_Psum,
  output logic                       Out_rdy,
  input  logic                       Out_ack,
  output logic [PEROW*DWD-1:0]       o_Out,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [1:0]                 dbg_state
);

  localparam int TLW = $clog2(DEPTH);
  localparam logic signed [ACCWD-1:0] OMAX = ACCWD'((1 << (DWD - 1)) - 1);
  localparam logic signed [ACCWD-1:0] OMIN = ~OMAX;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [TLW-1:0] wr_ptr, rd_ptr;
  logic [7:0]     pass_q;
  logic [TLW-1:0] tile_len_q;
  logic [7:0]     num_pass_q;
  logic [4:0]     shift_q;
  logic           relu_q;
  logic           done_q;

  // Tile buffer: no reset, every entry is written by pass 0 before any read.
  logic [ACCWD-1:0] acc_mem [DEPTH][PEROW];

  logic last_beat;
  logic last_pass;
  logic last_drain;

  assign last_beat  = (wr_ptr == tile_len_q);
  assign last_pass  = (pass_q == num_pass_q);
  assign last_drain = (rd_ptr == tile_len_q);

  // Sign-extend one incoming psum lane to accumulator width.
  function automatic logic [ACCWD-1:0] sext(input logic [PSUMDWD-1:0] p);
    return {{(ACCWD - PSUMDWD){p[PSUMDWD-1]}}, p};
  endfunction

  // Signed add that clamps to the accumulator range instead of wrapping.
  function automatic logic [ACCWD-1:0] sat_add(input logic [ACCWD-1:0] a,
                                               input logic [ACCWD-1:0] b);
    logic [ACCWD:0] s;
    s = {a[ACCWD-1], a} + {b[ACCWD-1], b};
    if (s[ACCWD] != s[ACCWD-1]) begin
      return s[ACCWD] ? {1'b1, {(ACCWD - 1){1'b0}}} : {1'b0, {(ACCWD - 1){1'b1}}};
    end
    return s[ACCWD-1:0];
  endfunction

  // Drain-side lane transform: floor shift, optional ReLU, clamp to DWD.
  function automatic logic [DWD-1:0] post(input logic [ACCWD-1:0] acc,
                                          input logic [4:0] sh,
                                          input logic rl);
    logic signed [ACCWD-1:0] t;
    t = $signed(acc) >>> sh;
    if (rl && (t < 0)) t = '0;
    if (t > OMAX) t = OMAX;
    else if (t < OMIN) t = OMIN;
    return t[DWD-1:0];
  endfunction

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state and handshake outputs.
  always_comb begin
    state_d  = state_q;
    Psum_ack = 1'b0;
    Out_rdy  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) state_d = ACC;
      end
      ACC: begin
        Psum_ack = 1'b1;
        if (Psum_rdy && last_beat && last_pass) state_d = DRAIN;
      end
      DRAIN: begin
        Out_rdy = 1'b1;
        if (Out_ack && last_drain) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Config latch, beat/pass/read pointers and the completion pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pass_q     <= '0;
      tile_len_q <= '0;
      num_pass_q <= '0;
      shift_q    <= '0;
      relu_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_start) begin
            tile_len_q <= i_tile_len;
            num_pass_q <= i_num_pass;
            shift_q    <= i_shift;
            relu_q     <= i_relu;
            wr_ptr     <= '0;
            pass_q     <= '0;
            rd_ptr     <= '0;
          end
        end
        ACC: begin
          if (Psum_rdy) begin
            if (last_beat) begin
              wr_ptr <= '0;
              pass_q <= pass_q + 8'd1;
              if (last_pass) rd_ptr <= '0;
            end else begin
              wr_ptr <= wr_ptr + TLW'(1);
            end
          end
        end
        DRAIN: begin
          if (Out_ack) begin
            if (last_drain) begin
              rd_ptr <= '0;
              done_q <= 1'b1;
            end else begin
              rd_ptr <= rd_ptr + TLW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Buffer update: pass 0 overwrites, later passes saturate-accumulate.
  always_ff @(posedge i_clk) begin
    if (!i_rst && (state_q == ACC) && Psum_rdy) begin
      for (int l = 0; l < PEROW; l++) begin
        if (pass_q == 8'd0)
          acc_mem[wr_ptr][l] <= sext(i_Psum[l*PSUMDWD +: PSUMDWD]);
        else
          acc_mem[wr_ptr][l] <= sat_add(acc_mem[wr_ptr][l], sext(i_Psum[l*PSUMDWD +: PSUMDWD]));
      end
    end
  end

  // Output activations, held at zero outside DRAIN.
  always_comb begin
    o_Out = '0;
    if (state_q == DRAIN) begin
      for (int l = 0; l < PEROW; l++) begin
        o_Out[l*DWD +: DWD] = post(acc_mem[rd_ptr][l], shift_q, relu_q);
      end
    end
  end

  assign o_busy    = (state_q != IDLE);
  assign o_done    = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_psum_drain.sv
// Bench for psum_drain: directed jobs from the test plan plus randomized jobs,
// checked against a per-lane arithmetic reference model.
module tb_psum_drain;

  localparam int PEROW   = 16;
  localparam int PSUMDWD = 24;
  localparam int ACCWD   = 28;
  localparam int DWD     = 8;
  localparam int DEPTH   = 16;
  localparam int MAXP    = 32;
  localparam int PMAX    = 8388607;
  localparam int PMIN    = -8388608;

  // Clock / reset and DUT signals.
  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start;
  logic [3:0]               tile_len;
  logic [7:0]               num_pass;
  logic [4:0]               shift;
  logic                     relu;
  logic                     psum_rdy;
  logic                     psum_ack;
  logic [PEROW*PSUMDWD-1:0] psum;
  logic                     out_rdy;
  logic                     out_ack;
  logic [PEROW*DWD-1:0]     out_data;
  logic                     busy;
  logic                     done;
  logic [1:0]               dbg_state;

  always #5 clk = ~clk;

  psum_drain #(
    .PEROW(PEROW), .PSUMDWD(PSUMDWD), .ACCWD(ACCWD), .DWD(DWD), .DEPTH(DEPTH)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_start(start),
    .i_tile_len(tile_len),
    .i_num_pass(num_pass),
    .i_shift(shift),
    .i_relu(relu),
    .Psum_rdy(psum_rdy),
    .Psum_ack(psum_ack),
    .i_Psum(psum),
    .Out_rdy(out_rdy),
    .Out_ack(out_ack),
    .o_Out(out_data),
    .o_busy(busy),
    .o_done(done),
    .dbg_state(dbg_state)
  );

  // Stimulus data for the current job: din[pass][beat][lane].
  int din [MAXP][DEPTH][PEROW];

  // Scoreboard.
  logic [PEROW*DWD-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference model: sum passes with per-step saturation, then shift/ReLU/clamp.
  function automatic logic [PEROW*DWD-1:0] model_beat(input int b, input int np,
                                                      input int sh, input int rl);
    logic [PEROW*DWD-1:0] r;
    longint amax, amin, a, t;
    amax = (longint'(1) << (ACCWD - 1)) - 1;
    amin = -amax - 1;
    r = '0;
    for (int l = 0; l < PEROW; l++) begin
      a = 0;
      for (int p = 0; p <= np; p++) begin
        a = a + longint'(din[p][b][l]);
        if (a > amax) a = amax;
        if (a < amin) a = amin;
      end
      t = a >>> sh;
      if (rl != 0 && t < 0) t = 0;
      if (t > 127) t = 127;
      if (t < -128) t = -128;
      r[l*DWD +: DWD] = t[DWD-1:0];
    end
    return r;
  endfunction

  task automatic fill_random(input int np, input int tl);
    for (int p = 0; p <= np; p++)
      for (int b = 0; b <= tl; b++)
        for (int l = 0; l < PEROW; l++)
          din[p][b][l] = int'($urandom_range(0, 16777215)) - 8388608;
  endtask

  // Driver: starts a job, feeds all passes, drains and scores the outputs.
  // Entered and left on a negedge; a following job may start on the cycle
  // that shows o_done.
  task automatic run_job(input string name, input int tl, input int np, input int sh,
                         input int rl, input int rdy_pct, input int ack_pct,
                         input int stall_at, input int abort_after);
    int total, sent, got, budget, stalls;
    logic rdy_now, ack_now;
    logic [PEROW*PSUMDWD-1:0] v;
    exp_q.delete();
    for (int b = 0; b <= tl; b++) exp_q.push_back(model_beat(b, np, sh, rl));

    check({name, "_idle_busy"}, 128'(busy), 128'(0));
    check({name, "_idle_psum_ack"}, 128'(psum_ack), 128'(0));
    start = 1'b1; tile_len = 4'(tl); num_pass = 8'(np); shift = 5'(sh); relu = rl[0];
    @(negedge clk);
    start = 1'b0;
    tile_len = 4'($urandom); num_pass = 8'($urandom); shift = 5'($urandom); relu = 1'($urandom);
    check({name, "_start_ack"}, 128'(psum_ack), 128'(1));
    check({name, "_start_busy"}, 128'(busy), 128'(1));
    check({name, "_done_clear"}, 128'(done), 128'(0));

    total = (tl + 1) * (np + 1);
    sent = 0;
    budget = 0;
    while (sent < total && budget < 20000) begin
      check({name, "_acc_ack"}, 128'(psum_ack), 128'(1));
      rdy_now = ($urandom_range(0, 99) < rdy_pct);
      for (int l = 0; l < PEROW; l++)
        v[l*PSUMDWD +: PSUMDWD] = rdy_now ? PSUMDWD'(din[sent / (tl + 1)][sent % (tl + 1)][l])
                                          : PSUMDWD'($urandom);
      psum_rdy = rdy_now;
      psum = v;
      @(negedge clk);
      if (rdy_now) sent++;
      budget++;
    end
    psum_rdy = 1'b0;
    check({name, "_acc_count"}, 128'(sent), 128'(total));
    check({name, "_ack_drop"}, 128'(psum_ack), 128'(0));
    check({name, "_out_rdy_rise"}, 128'(out_rdy), 128'(1));

    got = 0;
    budget = 0;
    stalls = 0;
    while (exp_q.size() > 0 && budget < 20000) begin
      check({name, "_drain_rdy"}, 128'(out_rdy), 128'(1));
      check({name, "_beat"}, 128'(out_data), 128'(exp_q[0]));
      if (abort_after >= 0 && got == abort_after) begin
        rst = 1'b1;
        out_ack = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check({name, "_rst_out_rdy"}, 128'(out_rdy), 128'(0));
        check({name, "_rst_psum_ack"}, 128'(psum_ack), 128'(0));
        check({name, "_rst_busy"}, 128'(busy), 128'(0));
        check({name, "_rst_out"}, 128'(out_data), 128'(0));
        exp_q.delete();
        return;
      end
      if (got == stall_at && stalls < 5) begin
        ack_now = 1'b0;
        stalls++;
      end else begin
        ack_now = ($urandom_range(0, 99) < ack_pct);
      end
      out_ack = ack_now;
      @(negedge clk);
      if (ack_now) begin
        void'(exp_q.pop_front());
        got++;
      end
      budget++;
    end
    out_ack = 1'b0;
    check({name, "_drain_left"}, 128'(exp_q.size()), 128'(0));
    check({name, "_done_pulse"}, 128'(done), 128'(1));
    check({name, "_end_busy"}, 128'(busy), 128'(0));
    check({name, "_end_out_rdy"}, 128'(out_rdy), 128'(0));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; tile_len = '0; num_pass = '0; shift = '0; relu = 1'b0;
    psum_rdy = 1'b0; psum = '0; out_ack = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state.
    check("rst_psum_ack", 128'(psum_ack), 128'(0));
    check("rst_out_rdy", 128'(out_rdy), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_out", 128'(out_data), 128'(0));
    @(negedge clk);

    // Single pass, lanes carry the beat index.
    for (int b = 0; b < 4; b++)
      for (int l = 0; l < PEROW; l++) din[0][b][l] = b;
    run_job("single", 3, 0, 0, 0, 100, 100, -1, -1);

    // Multi-pass accumulate: three passes of 10.
    for (int p = 0; p < 3; p++)
      for (int b = 0; b < 2; b++)
        for (int l = 0; l < PEROW; l++) din[p][b][l] = 10;
    run_job("multipass", 1, 2, 0, 0, 100, 100, -1, -1);

    // Shift / ReLU / clamp, with and without ReLU.
    for (int l = 0; l < PEROW; l++) din[0][0][l] = 0;
    din[0][0][0] = 1000; din[0][0][1] = -1000; din[0][0][2] = 40; din[0][0][3] = -5;
    run_job("relu_on", 0, 0, 2, 1, 100, 100, -1, -1);
    run_job("relu_off", 0, 0, 2, 0, 100, 100, -1, -1);

    // Accumulator saturation over 20 passes; lane 2 saturates then backs off.
    for (int p = 0; p < 20; p++)
      for (int l = 0; l < PEROW; l++)
        din[p][0][l] = (l % 2 == 0) ? PMAX : PMIN;
    for (int p = 17; p < 20; p++) din[p][0][2] = PMIN;
    for (int p = 0; p < 20; p++) din[p][0][3] = 1000;
    run_job("sat_shift", 0, 19, 20, 0, 100, 100, -1, -1);
    run_job("sat_noshift", 0, 19, 0, 0, 100, 100, -1, -1);

    // Backpressure: 5-cycle output stall mid-drain, random upstream gaps.
    fill_random(1, 3);
    run_job("stall", 3, 1, 12, 0, 50, 100, 2, -1);

    // Reset mid-drain after 2 of 4 beats, then an unrelated job.
    fill_random(0, 3);
    run_job("abort", 3, 0, 10, 0, 100, 100, -1, 2);
    fill_random(1, 2);
    run_job("after_abort", 2, 1, 14, 1, 70, 70, -1, -1);

    // Randomized jobs.
    for (int j = 0; j < 4; j++) begin
      int tl, np, sh, rl;
      tl = $urandom_range(0, DEPTH - 1);
      np = $urandom_range(0, 5);
      sh = $urandom_range(0, 24);
      rl = $urandom_range(0, 1);
      fill_random(np, tl);
      run_job($sformatf("rand%0d", j), tl, np, sh, rl, 60, 60, -1, -1);
    end

    @(negedge clk);
    check("final_done_low", 128'(done), 128'(0));
    check("final_busy", 128'(busy), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
